// File: rtl/wb_uart_tx_project.sv
// Wishbone-fed 8N1 UART transmitter project slot: byte FIFO, programmable baud
// divider and TX state machine, with tx/busy/full/overflow driven onto pads.
module wb_uart_tx_project #(
    parameter int          IO_WIDTH    = 38,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          TX_PIN      = 8,
    parameter int          CTS_PIN     = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_update,
    input  logic [31:0]         wb_data,
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          overflow_r;
    logic [15:0]   div_r;
    logic [15:0]   bit_div_r;
    logic [15:0]   timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [1:0]    state_r;

    logic [1:0] cmd_s;
    logic       push_s;
    logic       push_ok_s;
    logic       pop_s;
    logic       flush_s;
    logic       full_s;
    logic       timer_done_s;
    logic       tx_s;
    logic       unused_s;

    assign cmd_s        = wb_data[31:30];
    assign push_s       = wb_update && (cmd_s == 2'b00);
    assign flush_s      = wb_update && (cmd_s == 2'b10);
    assign full_s       = (count_r == CNT_FULL);
    assign push_ok_s    = push_s && !full_s;
    // CTS is active low; an unselected slot reads io_in as zero, i.e. clear to send.
    assign pop_s        = (state_r == ST_IDLE) && (count_r != '0) && !io_in[CTS_PIN];
    assign timer_done_s = (timer_r == bit_div_r - 16'd1);
    assign unused_s     = ^{wb_data[29:16], io_in};

    // FIFO storage write port (contents are don't-care while empty).
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wb_data[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                case ({push_ok_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
            // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
            if (push_s && full_s) begin
                overflow_r <= 1'b1;
            end else if (wb_update && (cmd_s == 2'b11)) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Baud divider register, clamped so every bit is at least four clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= DEFAULT_DIV;
        end else if (wb_update && (cmd_s == 2'b01)) begin
            div_r <= (wb_data[15:0] < 16'd4) ? 16'd4 : wb_data[15:0];
        end
    end

    // Transmit state machine; bit_div is frozen per frame so divider writes apply next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            bit_div_r <= DEFAULT_DIV;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timer_r <= 16'd0;
                    if (pop_s) begin
                        shift_r   <= mem_r[rd_ptr_r];
                        bit_div_r <= div_r;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_done_s) begin
                        timer_r   <= 16'd0;
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer_done_s) begin
                        timer_r <= 16'd0;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (timer_done_s) begin
                        timer_r <= 16'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                default: begin
                    timer_r <= 16'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Line level decoded purely from registered state.
    always_comb begin
        case (state_r)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_r[0];
            default:  tx_s = 1'b1;
        endcase
    end

    // Pad map: tx, busy, full, overflow; everything else driven low.
    always_comb begin
        io_out             = '0;
        io_out[TX_PIN]     = tx_s;
        io_out[TX_PIN + 1] = (state_r != ST_IDLE);
        io_out[TX_PIN + 2] = full_s;
        io_out[TX_PIN + 3] = overflow_r;
    end

endmodule
